ring_seq_monitor: RTL and testbench

- Downstream consumer of the 4-bit ring counter's one-hot Count_out; sits directly on that bus.
- Checks that the one-hot token rotates legally every clock, locks after a run of good steps, counts full revolutions and counts/flags sequence errors.
- Provides a binary phase index so later stages need not decode the one-hot bus.

---
 rtl/ring_pkg.sv | 28 ++
 rtl/ring_step_check.sv | 25 ++
 rtl/ring_seq_monitor.sv | 138 +++++++++++++
 tb/tb_ring_seq_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring counter sequence monitor.
// Holds the monitor FSM state encoding, the ring width and the one-hot helpers.
package ring_pkg;

  localparam int RING_W = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } ring_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [RING_W-1:0] value);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < RING_W; i++) begin
      if (value[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // dir = 0 moves the token towards the MSB, dir = 1 towards the LSB.
  function automatic logic [RING_W-1:0] rotate_ring(input logic [RING_W-1:0] value,
                                                    input logic dir);
    return dir ? {value[0], value[RING_W-1:1]} : {value[RING_W-2:0], value[RING_W-1]};
  endfunction

endpackage

// File: rtl/ring_step_check.sv
// Combinational classifier for one ring step (prev -> cur).
// Reports one-hotness of cur, legal rotation, repeated value and wrap into bit 0.
module ring_step_check
  import ring_pkg::*;
(
  input  logic [RING_W-1:0] prev,
  input  logic [RING_W-1:0] cur,
  input  logic              dir,
  output logic              is_onehot,
  output logic              legal,
  output logic              is_hold,
  output logic              wrap
);

  logic prev_onehot;

  always_comb begin
    is_onehot   = (cur != '0) && ((cur & (cur - 1'b1)) == '0);
    prev_onehot = (prev != '0) && ((prev & (prev - 1'b1)) == '0);
    legal       = is_onehot && prev_onehot && (cur == rotate_ring(prev, dir));
    is_hold     = is_onehot && (cur == prev);
    wrap        = legal && (cur == {{(RING_W-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/ring_seq_monitor.sv
// Watches a one-hot ring counter bus, locks onto legal rotation, counts revolutions and errors.
// Optional macro RING_SEQ_MONITOR_HOLD_EN accepts a repeated one-hot value as a legal hold.
module ring_seq_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int REV_W    = 8,
  parameter int ERR_W    = 8,
  parameter bit DIR      = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Ring_in,
  input  logic             Clear,
  output logic [1:0]       Phase,
  output logic             Locked,
  output logic             Error_pulse,
  output logic             Error_sticky,
  output logic [REV_W-1:0] Rev_count,
  output logic [ERR_W-1:0] Err_count
);

`ifdef RING_SEQ_MONITOR_HOLD_EN
  localparam bit HOLD_ENABLE = 1'b1;
`else
  localparam bit HOLD_ENABLE = 1'b0;
`endif

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

  ring_state_e      state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [1:0]       phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic             sticky_q, sticky_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic is_onehot, legal, is_hold, wrap, hold_ok;
  logic err_evt, rev_evt;

  ring_step_check u_step_check (
    .prev      (prev_q),
    .cur       (Ring_in),
    .dir       (DIR),
    .is_onehot (is_onehot),
    .legal     (legal),
    .is_hold   (is_hold),
    .wrap      (wrap)
  );

  assign hold_ok = is_hold & HOLD_ENABLE;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= HUNT;
      good_q   <= '0;
      prev_q   <= '0;
      phase_q  <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      rev_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      prev_q   <= prev_d;
      phase_q  <= phase_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      rev_q    <= rev_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_evt = 1'b0;
    rev_evt = 1'b0;
    case (state_q)
      HUNT: begin
        if (is_onehot) begin
          state_d = SYNC;
          good_d  = '0;
        end
      end
      SYNC: begin
        if (legal) begin
          good_d = good_q + 4'd1;
          if (good_d == LOCK_TARGET) state_d = LOCKED;
        end else if (!hold_ok) begin
          good_d = '0;
          if (!is_onehot) state_d = HUNT;
        end
      end
      LOCKED: begin
        if (legal) begin
          rev_evt = wrap;
        end else if (!hold_ok) begin
          err_evt = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Locked tracks staying in LOCKED across this step, so it drops together with Error_pulse.
  always_comb begin
    prev_d   = Ring_in;
    phase_d  = is_onehot ? onehot_to_idx(Ring_in) : phase_q;
    locked_d = (state_q == LOCKED) && (state_d == LOCKED);
    pulse_d  = err_evt;
    sticky_d = Clear ? err_evt : (sticky_q | err_evt);
    rev_d    = Clear ? '0 : (rev_q + REV_W'(rev_evt));
    if (Clear) begin
      err_d = '0;
    end else if (err_evt && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  assign Phase        = phase_q;
  assign Locked       = locked_q;
  assign Error_pulse  = pulse_q;
  assign Error_sticky = sticky_q;
  assign Rev_count    = rev_q;
  assign Err_count    = err_q;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Randomized scoreboard bench for ring_seq_monitor: default-width DUT plus a 2-bit counter DUT.
// The reference model works on token positions with modular arithmetic; honours RING_SEQ_MONITOR_HOLD_EN.
module tb_ring_seq_monitor;

  typedef struct packed {
    logic [1:0] phase;
    logic       locked;
    logic       pulse;
    logic       sticky;
    logic [7:0] rev;
    logic [7:0] err;
  } obs_t;

`ifdef RING_SEQ_MONITOR_HOLD_EN
  localparam bit HOLD_MODEL = 1'b1;
`else
  localparam bit HOLD_MODEL = 1'b0;
`endif

  localparam int LOCK_STEPS = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] ring_in = 4'd0;
  logic       clear = 1'b0;

  logic [1:0] phase_a, phase_b;
  logic       locked_a, locked_b, pulse_a, pulse_b, sticky_a, sticky_b;
  logic [7:0] rev_a, err_a;
  logic [1:0] rev_b, err_b;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle_no = 0;

  obs_t exp_q_a[$];
  obs_t exp_q_b[$];

  // Reference model state: mode 0 = hunting, 1 = synchronising, 2 = locked.
  logic [3:0] m_prev;
  int m_mode, m_good, m_phase, m_rev_a, m_rev_b, m_err_a, m_err_b;
  bit m_sticky;

  always #5 clock = ~clock;

  ring_seq_monitor dut_a (
    .Clock(clock), .Reset(reset_n), .Ring_in(ring_in), .Clear(clear),
    .Phase(phase_a), .Locked(locked_a), .Error_pulse(pulse_a), .Error_sticky(sticky_a),
    .Rev_count(rev_a), .Err_count(err_a)
  );

  ring_seq_monitor #(.REV_W(2), .ERR_W(2)) dut_b (
    .Clock(clock), .Reset(reset_n), .Ring_in(ring_in), .Clear(clear),
    .Phase(phase_b), .Locked(locked_b), .Error_pulse(pulse_b), .Error_sticky(sticky_b),
    .Rev_count(rev_b), .Err_count(err_b)
  );

  function automatic int bit_count(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int position(input logic [3:0] v);
    int p = 0;
    for (int i = 0; i < 4; i++) if (v[i]) p = i;
    return p;
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic clr, input logic [3:0] ring);
    obs_t ea, eb;
    bit cur_oh, prev_oh, step_ok, hold, err, rev;
    int old_mode;
    @(negedge clock);
    reset_n = rst_n;
    clear   = clr;
    ring_in = ring;
    cycle_no++;
    if (!rst_n) begin
      m_prev = 4'd0; m_mode = 0; m_good = 0; m_phase = 0;
      m_rev_a = 0; m_rev_b = 0; m_err_a = 0; m_err_b = 0; m_sticky = 0;
      ea = '0;
    end else begin
      cur_oh  = (bit_count(ring) == 1);
      prev_oh = (bit_count(m_prev) == 1);
      step_ok = cur_oh && prev_oh && (position(ring) == (position(m_prev) + 1) % 4);
      hold    = HOLD_MODEL && cur_oh && (ring == m_prev);
      err = 0;
      rev = 0;
      old_mode = m_mode;
      if (m_mode == 0) begin
        if (cur_oh) begin m_mode = 1; m_good = 0; end
      end else if (m_mode == 1) begin
        if (step_ok) begin
          m_good++;
          if (m_good == LOCK_STEPS) m_mode = 2;
        end else if (!hold) begin
          m_good = 0;
          if (!cur_oh) m_mode = 0;
        end
      end else begin
        if (step_ok) rev = (position(ring) == 0);
        else if (!hold) begin err = 1; m_mode = 0; end
      end
      if (cur_oh) m_phase = position(ring);
      if (clr) begin
        m_rev_a = 0; m_rev_b = 0; m_err_a = 0; m_err_b = 0; m_sticky = err;
      end else begin
        if (rev) begin m_rev_a = (m_rev_a + 1) % 256; m_rev_b = (m_rev_b + 1) % 4; end
        if (err) begin
          if (m_err_a < 255) m_err_a++;
          if (m_err_b < 3) m_err_b++;
        end
        m_sticky = m_sticky | err;
      end
      m_prev = ring;
      ea.phase  = 2'(m_phase);
      ea.locked = (old_mode == 2) && (m_mode == 2);
      ea.pulse  = err;
      ea.sticky = m_sticky;
      ea.rev    = 8'(m_rev_a);
      ea.err    = 8'(m_err_a);
    end
    eb = ea;
    eb.rev = 8'(m_rev_b);
    eb.err = 8'(m_err_b);
    exp_q_a.push_back(ea);
    exp_q_b.push_back(eb);
  endtask

  task automatic checkOutput(input string name, input obs_t got, input obs_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got phase=%0d locked=%0b pulse=%0b sticky=%0b rev=%0d err=%0d, required phase=%0d locked=%0b pulse=%0b sticky=%0b rev=%0d err=%0d",
               name, cycle_no, got.phase, got.locked, got.pulse, got.sticky, got.rev, got.err,
               exp.phase, exp.locked, exp.pulse, exp.sticky, exp.rev, exp.err);
    end
  endtask

  always @(posedge clock) begin
    obs_t ga, gb, ea, eb;
    #1;
    if (exp_q_a.size() > 0 && exp_q_b.size() > 0) begin
      ea = exp_q_a.pop_front();
      eb = exp_q_b.pop_front();
      ga = {phase_a, locked_a, pulse_a, sticky_a, rev_a, err_a};
      gb = {phase_b, locked_b, pulse_b, sticky_b, {6'd0, rev_b}, {6'd0, err_b}};
      checkOutput("dut_a", ga, ea);
      checkOutput("dut_b", gb, eb);
    end
  end

  initial begin
    int pos;
    int r;
    int waited;
    logic [3:0] ring;
    bit clr, rst_n, cleared_on_wrap;
    pos = 3;
    ring = 4'd0;
    cleared_on_wrap = 0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Clean run from 0001 long enough for many revolutions, with one Clear on a wrap.
    for (int i = 0; i < 70; i++) begin
      pos = (pos + 1) % 4;
      ring = 4'b0001 << pos;
      clr = 0;
      if (i > 40 && pos == 0 && !cleared_on_wrap) begin clr = 1; cleared_on_wrap = 1; end
      applyStimulus(1'b1, clr, ring);
    end

    // Skip a position while locked, then resume the legal sequence.
    pos = (pos + 2) % 4;
    applyStimulus(1'b1, 1'b0, 4'b0001 << pos);
    for (int i = 0; i < 12; i++) begin
      pos = (pos + 1) % 4;
      applyStimulus(1'b1, 1'b0, 4'b0001 << pos);
    end

    // Hold the current value for a cycle while locked.
    applyStimulus(1'b1, 1'b0, 4'b0001 << pos);
    for (int i = 0; i < 8; i++) begin
      pos = (pos + 1) % 4;
      applyStimulus(1'b1, 1'b0, 4'b0001 << pos);
    end

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 86) begin
        pos = (pos + 1) % 4;
        ring = 4'b0001 << pos;
      end else if (r < 90) begin
        ring = 4'($urandom_range(0, 15));
        if (bit_count(ring) == 1) pos = position(ring);
      end else if (r < 94) begin
        ring = 4'b0001 << pos;
      end else if (r < 97) begin
        pos = (pos + 2) % 4;
        ring = 4'b0001 << pos;
      end else begin
        pos = (pos + 3) % 4;
        ring = 4'b0001 << pos;
      end
      clr   = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 249) != 0);
      applyStimulus(rst_n, clr, ring);
    end

    waited = 0;
    while ((exp_q_a.size() > 0 || exp_q_b.size() > 0) && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    #2;
    if (exp_q_a.size() > 0 || exp_q_b.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: got %0d entries left, required 0", exp_q_a.size() + exp_q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
